// File: rtl/reset_seq_pkg.sv
// Shared state encoding and sizing helper for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {RESET, HOLD, STAGE, RUN} seq_state_e;

  localparam logic [1:0] ST_RESET = 2'b00;
  localparam logic [1:0] ST_HOLD  = 2'b01;
  localparam logic [1:0] ST_STAGE = 2'b10;
  localparam logic [1:0] ST_RUN   = 2'b11;

  // Bits needed for a counter whose terminal value is n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and the pipeline it brings up.
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_W      = 32
);
  logic                  soft_rst_req;
  logic                  wdt_kick;
  logic                  rst_out_n;
  logic [NUM_STAGES-1:0] stage_en;
  logic                  ready;
  logic [1:0]            state;
  logic [CNT_W-1:0]      cycle_count;
  logic                  wdt_expired;

  modport master (
    input  soft_rst_req, wdt_kick,
    output rst_out_n, stage_en, ready, state, cycle_count, wdt_expired
  );

  modport slave (
    output soft_rst_req, wdt_kick,
    input  rst_out_n, stage_en, ready, state, cycle_count, wdt_expired
  );
endinterface

// File: rtl/seq_timer.sv
// Up-counter with synchronous clear; done flags the enabled edge at the terminal value.
module seq_timer #(
  parameter int W = 4
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_clear,
  input  logic         i_enable,
  input  logic [W-1:0] i_terminal,
  output logic         o_done
);
  logic [W-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (!i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_done = i_enable && (r_count == i_terminal);
endmodule

// File: rtl/reset_sequencer.sv
// Stretched reset and staggered stage enables for the NN pipeline.
// Optional stall watchdog built when RESET_SEQ_WATCHDOG_EN is defined.
//   state | meaning
//   RESET | raw reset asserted, everything cleared
//   HOLD  | rst_out_n held low for HOLD_CYCLES edges
//   STAGE | stage enables switched on one per STAGE_GAP edges
//   RUN   | all stages up, ready=1, cycle_count running
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_GAP   = 8,
  parameter int CNT_W       = 32,
  parameter int WDT_CYCLES  = 1024
) (
  input  logic               i_clock,
  input  logic               i_reset,
  reset_sequencer_if.master  bus
);
  localparam int HOLD_W = cnt_width(HOLD_CYCLES);
  localparam int GAP_W  = cnt_width(STAGE_GAP);

  logic [1:0]            r_state;
  logic                  r_rst_out_n;
  logic [NUM_STAGES-1:0] r_stage_en;
  logic                  r_ready;
  logic [CNT_W-1:0]      r_cycle_count;
  logic                  r_wdt_expired;

  logic                  w_hold_done;
  logic                  w_gap_done;
  logic                  w_wdt_fire;
  logic                  w_restart;
  logic [NUM_STAGES:0]   w_shift;

  assign w_restart = (r_state != ST_RESET) && (bus.soft_rst_req || w_wdt_fire);
  assign w_shift   = {r_stage_en, 1'b1};

  seq_timer #(.W(HOLD_W)) u_hold_timer (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_clear    ((r_state != ST_HOLD) || w_restart || w_hold_done),
    .i_enable   (r_state == ST_HOLD),
    .i_terminal (HOLD_W'(HOLD_CYCLES - 1)),
    .o_done     (w_hold_done)
  );

  seq_timer #(.W(GAP_W)) u_gap_timer (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_clear    ((r_state != ST_STAGE) || w_restart || w_gap_done),
    .i_enable   (r_state == ST_STAGE),
    .i_terminal (GAP_W'(STAGE_GAP - 1)),
    .o_done     (w_gap_done)
  );

`ifdef RESET_SEQ_WATCHDOG_EN
  localparam int WDT_W = cnt_width(WDT_CYCLES);
  logic w_wdt_done;

  // Terminal is WDT_CYCLES-2: firing on the edge that would make the count WDT_CYCLES-1.
  seq_timer #(.W(WDT_W)) u_wdt_timer (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_clear    ((r_state != ST_RUN) || bus.wdt_kick || w_restart),
    .i_enable   (r_state == ST_RUN),
    .i_terminal (WDT_W'(WDT_CYCLES - 2)),
    .o_done     (w_wdt_done)
  );

  assign w_wdt_fire = w_wdt_done && !bus.wdt_kick;
`else
  assign w_wdt_fire = bus.wdt_kick & 1'b0;
`endif

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state       <= ST_RESET;
      r_rst_out_n   <= 1'b0;
      r_stage_en    <= '0;
      r_ready       <= 1'b0;
      r_cycle_count <= '0;
      r_wdt_expired <= 1'b0;
    end else begin
      if (w_wdt_fire) r_wdt_expired <= 1'b1;
      if (r_state == ST_RESET) begin
        r_state <= ST_HOLD;
      end else if (w_restart) begin
        r_state       <= ST_HOLD;
        r_rst_out_n   <= 1'b0;
        r_stage_en    <= '0;
        r_ready       <= 1'b0;
        r_cycle_count <= '0;
      end else begin
        case (r_state)
          ST_HOLD: if (w_hold_done) begin
            r_state     <= ST_STAGE;
            r_rst_out_n <= 1'b1;
          end
          ST_STAGE: if (w_gap_done) begin
            r_stage_en <= w_shift[NUM_STAGES-1:0];
            if (w_shift[NUM_STAGES-1]) begin
              r_state       <= ST_RUN;
              r_ready       <= 1'b1;
              r_cycle_count <= '0;
            end
          end
          default: if (r_cycle_count != {CNT_W{1'b1}}) begin
            r_cycle_count <= r_cycle_count + CNT_W'(1);
          end
        endcase
      end
    end
  end

  assign bus.rst_out_n   = r_rst_out_n;
  assign bus.stage_en    = r_stage_en;
  assign bus.ready       = r_ready;
  assign bus.state       = r_state;
  assign bus.cycle_count = r_cycle_count;
  assign bus.wdt_expired = r_wdt_expired;
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: timeline model driven from the sequence start edge, plus literal checkpoints.
module tb_reset_sequencer;
  localparam int H      = 16;
  localparam int NS     = 4;
  localparam int G      = 8;
  localparam int CW     = 32;
  localparam int WDT    = 1024;
  localparam int RUN_AT = H + G * NS;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  reset_sequencer_if #(.NUM_STAGES(NS), .CNT_W(CW)) u_if ();
  reset_sequencer_if #(.NUM_STAGES(NS), .CNT_W(4))  u_if4 ();
  assign u_if4.soft_rst_req = u_if.soft_rst_req;
  assign u_if4.wdt_kick     = u_if.wdt_kick;

  reset_sequencer #(.HOLD_CYCLES(H), .NUM_STAGES(NS), .STAGE_GAP(G), .CNT_W(CW), .WDT_CYCLES(WDT))
    dut (.i_clock(clock), .i_reset(reset), .bus(u_if.master));
  reset_sequencer #(.HOLD_CYCLES(H), .NUM_STAGES(NS), .STAGE_GAP(G), .CNT_W(4), .WDT_CYCLES(WDT))
    dut4 (.i_clock(clock), .i_reset(reset), .bus(u_if4.master));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: outputs follow from the edge index at which the current sequence started.
  int n       = -1;
  int t_start = 0;
  int t_kick  = -1;
  bit m_valid = 0;
  bit m_inrst = 1;
  bit m_wdt   = 0;

  function automatic int e_state(input int k);
    if (m_inrst) return 0;
    if (k - t_start < H) return 1;
    if (k - t_start < RUN_AT) return 2;
    return 3;
  endfunction

  function automatic int e_nst(input int k);
    if (e_state(k) == 3) return NS;
    if (e_state(k) == 2) return (k - t_start - H) / G;
    return 0;
  endfunction

  function automatic longint e_cc(input int k, input int w);
    longint lim;
    longint v;
    lim = (longint'(1) << w) - 1;
    if (e_state(k) != 3) return 0;
    v = longint'(k - t_start - RUN_AT);
    return (v > lim) ? lim : v;
  endfunction

  always @(posedge clock) begin
    bit fire;
    int lastclr;
    fire = 0;
    n++;
    if (!reset) begin
      m_inrst = 1;
      m_wdt   = 0;
      m_valid = 1;
    end else if (m_inrst) begin
      m_inrst = 0;
      t_start = n;
    end else begin
`ifdef RESET_SEQ_WATCHDOG_EN
      if (e_state(n - 1) == 3) begin
        lastclr = (t_kick > t_start + RUN_AT) ? t_kick : t_start + RUN_AT;
        fire = ((n - 1 - lastclr) == WDT - 2) && !u_if.wdt_kick;
        if (u_if.wdt_kick) t_kick = n;
      end
`endif
      if (fire) m_wdt = 1;
      if (u_if.soft_rst_req || fire) t_start = n;
    end
    #1;
    if (m_valid) begin
      check("state",       u_if.state,        e_state(n));
      check("rst_out_n",   u_if.rst_out_n,    e_state(n) >= 2);
      check("stage_en",    u_if.stage_en,     (1 << e_nst(n)) - 1);
      check("ready",       u_if.ready,        e_state(n) == 3);
      check("cycle_count", u_if.cycle_count,  e_cc(n, CW));
      check("cc_w4",       u_if4.cycle_count, e_cc(n, 4));
      check("wdt_expired", u_if.wdt_expired,  m_wdt);
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clock);
    #2;
  endtask

  initial begin
    u_if.soft_rst_req = 1'b0;
    u_if.wdt_kick     = 1'b0;
    reset = 1'b0;
    tick(5);
    check("lit_rst_state", u_if.state, 0);
    check("lit_rst_out_n", u_if.rst_out_n, 0);
    check("lit_rst_stage", u_if.stage_en, 0);
    check("lit_rst_ready", u_if.ready, 0);

    reset = 1'b1;
    tick(1);
    check("lit_e0_state", u_if.state, 1);
    tick(15);
    check("lit_e15_rst_out_n", u_if.rst_out_n, 0);
    tick(1);
    check("lit_e16_rst_out_n", u_if.rst_out_n, 1);
    tick(8);
    check("lit_e24_stage", u_if.stage_en, 4'b0001);
    tick(8);
    check("lit_e32_stage", u_if.stage_en, 4'b0011);
    tick(8);
    check("lit_e40_stage", u_if.stage_en, 4'b0111);
    tick(8);
    check("lit_e48_stage", u_if.stage_en, 4'b1111);
    check("lit_e48_ready", u_if.ready, 1);
    check("lit_e48_state", u_if.state, 3);
    tick(100);
    check("lit_cc100", u_if.cycle_count, 100);
    check("lit_cc_w4_sat", u_if4.cycle_count, 15);

    // soft restart from RUN, then again mid-STAGE at 0011
    u_if.soft_rst_req = 1'b1;
    tick(1);
    u_if.soft_rst_req = 1'b0;
    check("lit_soft_state", u_if.state, 1);
    tick(32);
    check("lit_soft_stage0011", u_if.stage_en, 4'b0011);
    u_if.soft_rst_req = 1'b1;
    tick(1);
    u_if.soft_rst_req = 1'b0;
    check("lit_req_state", u_if.state, 1);
    check("lit_req_rst_out_n", u_if.rst_out_n, 0);
    check("lit_req_stage", u_if.stage_en, 0);
    tick(15);
    check("lit_req15_rst_out_n", u_if.rst_out_n, 0);
    tick(1);
    check("lit_req16_rst_out_n", u_if.rst_out_n, 1);
    tick(31);
    check("lit_req47_ready", u_if.ready, 0);
    tick(1);
    check("lit_req48_ready", u_if.ready, 1);

    // reset wins over soft request mid-HOLD
    u_if.soft_rst_req = 1'b1;
    tick(1);
    u_if.soft_rst_req = 1'b0;
    tick(5);
    reset = 1'b0;
    u_if.soft_rst_req = 1'b1;
    tick(1);
    check("lit_both_state", u_if.state, 0);
    check("lit_both_rst_out_n", u_if.rst_out_n, 0);
    check("lit_both_cc", u_if.cycle_count, 0);
    reset = 1'b1;
    u_if.soft_rst_req = 1'b0;
    tick(1);
    tick(RUN_AT);
    check("lit_wd_run", u_if.state, 3);

`ifdef RESET_SEQ_WATCHDOG_EN
    repeat (5) begin
      tick(999);
      u_if.wdt_kick = 1'b1;
      tick(1);
      u_if.wdt_kick = 1'b0;
    end
    check("lit_kicked_wdt", u_if.wdt_expired, 0);
    check("lit_kicked_state", u_if.state, 3);
    tick(1022);
    u_if.wdt_kick = 1'b1;
    tick(1);
    u_if.wdt_kick = 1'b0;
    check("lit_term_kick_wdt", u_if.wdt_expired, 0);
    check("lit_term_kick_state", u_if.state, 3);
    tick(1022);
    check("lit_pre_expiry_wdt", u_if.wdt_expired, 0);
    tick(1);
    check("lit_expiry_wdt", u_if.wdt_expired, 1);
    check("lit_expiry_state", u_if.state, 1);
`else
    u_if.wdt_kick = 1'b0;
    tick(5000);
    check("lit_nowdt_state", u_if.state, 3);
    check("lit_nowdt_wdt", u_if.wdt_expired, 0);
    check("lit_nowdt_ready", u_if.ready, 1);
`endif

    // randomized: busy blocks with frequent events, quiet blocks with rare kicks
    for (int i = 0; i < 6000; i++) begin
      if (((i / 1500) % 2) == 1) begin
        reset             = 1'b1;
        u_if.soft_rst_req = 1'b0;
        u_if.wdt_kick     = ($urandom_range(0, 1499) == 0);
      end else begin
        reset             = ($urandom_range(0, 299) != 0);
        u_if.soft_rst_req = ($urandom_range(0, 99) == 0);
        u_if.wdt_kick     = ($urandom_range(0, 2) == 0);
      end
      tick(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
